regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the core's decode/execute boundary; successor of the single-write, two-read register file.
- Adds:
  - configurable read-port count;
  - optional hardwired-zero entry 0;
  - optional write-to-read bypass;
  - synchronous active-low reset;
  - a sequential clear engine that zeroes the whole array one entry per cycle after reset or on request.
- Reads are registered: 1-cycle latency, gated by ce.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of entries (2..256, need not be a power of two).
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read.
- localparam IDX_W = $clog2(NREGS), minimum 1.

Ports:
- clk  input  1  Single clock; all logic on posedge.
- rst_n  input  1  Reset, synchronous, active-low.
- ce  input  1  Clock enable for the write port and read registers.
- write_en  input  1  Write request.
- rd_idx  input  IDX_W  Write index.
- data_in  input  XLEN  Write data.
- rs_idx  input  NREAD*IDX_W  Read indices; port p uses bits [p*IDX_W +: IDX_W].
- rs_data  output  NREAD*XLEN  Registered read data; port p uses bits [p*XLEN +: XLEN].
- clear_req  input  1  Request a full-array clear sweep.
- busy  output  1  High while a clear sweep is in progress.

Behaviour:

Reset
- rst_n low at a posedge:
  - all rs_data = 0, busy = 1, state = CLEAR, clear pointer = 0;
  - the array is not written in that cycle.
- Held low: these values persist.
- rst_n low mid-sweep restarts the sweep at pointer 0.

FSM states: CLEAR and IDLE.

CLEAR
- Each posedge with rst_n high writes 0 to entry[ptr] and increments ptr; ce is ignored.
- When ptr = NREGS-1 is written, next state = IDLE and busy = 0 (registered).
- busy therefore falls exactly NREGS posedges after the first posedge with rst_n high.
- During CLEAR:
  - write_en is dropped;
  - rs_data holds its value;
  - clear_req is ignored.

IDLE, clear_req = 1 at a posedge (independent of ce)
- Next state = CLEAR, ptr = 0, busy = 1.
- clear_req has priority over a write: any write in that cycle is dropped.
- Reads in that cycle update normally from the pre-clear array, with no bypass.

IDLE, ce = 1, clear_req = 0
- Write: entry[rd_idx] <= data_in when all of the following hold:
  - write_en = 1;
  - rd_idx < NREGS;
  - not (ZERO_REG and rd_idx = 0).
- Each read port p, in this priority order:
  1. rs_idx_p >= NREGS → 0.
  2. ZERO_REG and rs_idx_p = 0 → 0.
  3. BYPASS and a write is performed this cycle and rd_idx = rs_idx_p → data_in.
  4. Otherwise → array content before this edge.
- With BYPASS = 0, a matching read returns the old value.

IDLE, ce = 0
- No write; rs_data holds.

General rules
- All read ports are independent: the same index on several ports is legal and returns identical data.
- Array contents are undefined only before the first completed sweep. Reads during that window return whatever the read rules give, but busy = 1 flags it.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset sweep, NREGS=32: rst_n low 2 cycles then high → busy = 1 for exactly 32 posedges after release, then 0. After that, reading idx 5 and 31 → 0x00000000.
2. Write/read latency: write 0xDEADBEEF to x7 (ce=1). Next cycle rs_idx0 = 7 → rs_data0 = 0xDEADBEEF one cycle later. With ce=0 on the read cycle → rs_data0 holds its previous value.
3. Bypass: in one cycle, write 0x12345678 to x3 and read x3 on port 1. BYPASS=1 → 0x12345678 after 1 cycle. BYPASS=0 → old value 0.
4. Zero register: write 0xFFFFFFFF to x0, then read x0 on all ports → 0 (ZERO_REG=1). With ZERO_REG=0 → 0xFFFFFFFF.
5. Clear request:
   - Fill x1..x31 with nonzero values.
   - Pulse clear_req together with a write of 0xAA to x4 → write dropped, busy high for 32 cycles.
   - Writes issued during busy are dropped.
   - Afterwards all entries read 0.
6. Reset mid-sweep and out-of-range index:
   - rst_n low at ptr = 10 → sweep restarts; busy falls 32 cycles after release.
   - With NREGS=24, reading idx 30 → 0 and writing idx 30 has no effect.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bundle between the decode/execute stage and the register file: one write
// port, NREAD registered read ports, the clear request and the sweep status.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREAD = 2,
  parameter int IDX_W = 5
);
  // No valid/ready pairing: a write is accepted on any posedge where ce and
  // write_en are high and no sweep is running; read data appears one ce-qualified
  // edge after rs_idx is presented; busy high means the array is being zeroed.
  logic                   ce;
  logic                   write_en;
  logic [IDX_W-1:0]       rd_idx;
  logic [XLEN-1:0]        data_in;
  logic [NREAD*IDX_W-1:0] rs_idx;
  logic [NREAD*XLEN-1:0]  rs_data;
  logic                   clear_req;
  logic                   busy;
  logic                   dbg_state;

  modport master (
    output ce, write_en, rd_idx, data_in, rs_idx, clear_req,
    input  rs_data, busy, dbg_state
  );

  modport slave (
    input  ce, write_en, rd_idx, data_in, rs_idx, clear_req,
    output rs_data, busy, dbg_state
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads, optional zero entry,
// optional write-to-read bypass and a one-entry-per-cycle clear sweep.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int IDX_W   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam logic [0:0]       ST_CLEAR = 1'b0;
  localparam logic [0:0]       ST_IDLE  = 1'b1;
  localparam logic [IDX_W:0]   NREGS_W  = (IDX_W+1)'(NREGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  logic [XLEN-1:0]       r_mem [NREGS];
  logic [0:0]            r_state;
  logic [IDX_W-1:0]      r_ptr;
  logic                  r_busy;
  logic [NREAD*XLEN-1:0] r_rs_data;

  logic                  w_rd_en;
  logic                  w_wr_fire;
  logic [IDX_W-1:0]      w_rs_idx;
  logic [NREAD*XLEN-1:0] w_rd_next;

  // Read registers update in IDLE with ce, including the clear_req cycle;
  // a clear request suppresses the write, which also disables the bypass.
  assign w_rd_en   = (r_state == ST_IDLE) && bus.ce;
  assign w_wr_fire = w_rd_en && !bus.clear_req && bus.write_en &&
                     ({1'b0, bus.rd_idx} < NREGS_W) &&
                     !((ZERO_REG != 0) && (bus.rd_idx == '0));

  always_comb begin
    w_rd_next = '0;
    w_rs_idx  = '0;
    for (int p = 0; p < NREAD; p++) begin
      w_rs_idx = bus.rs_idx[p*IDX_W +: IDX_W];
      if ({1'b0, w_rs_idx} < NREGS_W) begin
        if ((ZERO_REG != 0) && (w_rs_idx == '0))
          w_rd_next[p*XLEN +: XLEN] = '0;
        else if ((BYPASS != 0) && w_wr_fire && (bus.rd_idx == w_rs_idx))
          w_rd_next[p*XLEN +: XLEN] = bus.data_in;
        else
          w_rd_next[p*XLEN +: XLEN] = r_mem[w_rs_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_ptr     <= '0;
      r_busy    <= 1'b1;
      r_rs_data <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_ptr == LAST_IDX) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + IDX_W'(1);
          end
        end
        default: begin
          if (bus.clear_req) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
          if (w_rd_en) r_rs_data <= w_rd_next;
        end
      endcase
    end
  end

  // Storage has no reset; the sweep is what makes its contents defined.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == ST_CLEAR)
        r_mem[r_ptr] <= '0;
      else if (w_wr_fire)
        r_mem[bus.rd_idx] <= bus.data_in;
    end
  end

  assign bus.rs_data   = r_rs_data;
  assign bus.busy      = r_busy;
  assign bus.dbg_state = r_state[0];

endmodule

// File: tb/tb_regfile_mp.sv
// Two register-file configurations driven in lockstep and checked against a
// reference model through an expected-value queue.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREAD = 2;
  localparam int IDX_W = 5;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   t_ce = 1'b0;
  logic                   t_we = 1'b0;
  logic                   t_clr = 1'b0;
  logic [IDX_W-1:0]       t_rd = '0;
  logic [XLEN-1:0]        t_din = '0;
  logic [NREAD*IDX_W-1:0] t_rs = '0;

  regfile_mp_if #(.XLEN(XLEN), .NREAD(NREAD), .IDX_W(IDX_W)) bus_a ();
  regfile_mp_if #(.XLEN(XLEN), .NREAD(NREAD), .IDX_W(IDX_W)) bus_b ();

  assign bus_a.ce = t_ce;  assign bus_a.write_en = t_we;  assign bus_a.rd_idx = t_rd;
  assign bus_a.data_in = t_din;  assign bus_a.rs_idx = t_rs;  assign bus_a.clear_req = t_clr;
  assign bus_b.ce = t_ce;  assign bus_b.write_en = t_we;  assign bus_b.rd_idx = t_rd;
  assign bus_b.data_in = t_din;  assign bus_b.rs_idx = t_rs;  assign bus_b.clear_req = t_clr;

  regfile_mp #(.XLEN(XLEN), .NREGS(32), .NREAD(NREAD), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  regfile_mp #(.XLEN(XLEN), .NREGS(24), .NREAD(NREAD), .ZERO_REG(0), .BYPASS(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];

  int   cfg_n [2] = '{32, 24};
  bit   cfg_z [2] = '{1'b1, 1'b0};
  bit   cfg_b [2] = '{1'b1, 1'b0};
  logic [XLEN-1:0] m_mem [2][32];
  logic [XLEN-1:0] m_rs  [2][2];
  bit   m_clear [2];
  int   m_ptr   [2];

  task automatic check_val(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input int c, input bit rst_low, input bit ce, input bit we, input int rd,
                            input logic [XLEN-1:0] din, input int rs0, input int rs1, input bit clr);
    bit wfire;
    int idx;
    logic [XLEN-1:0] v;
    if (rst_low) begin
      m_clear[c] = 1'b1;
      m_ptr[c]   = 0;
      m_rs[c][0] = '0;
      m_rs[c][1] = '0;
    end else if (m_clear[c]) begin
      m_mem[c][m_ptr[c]] = '0;
      m_ptr[c]++;
      if (m_ptr[c] == cfg_n[c]) m_clear[c] = 1'b0;
    end else begin
      wfire = ce && !clr && we && (rd < cfg_n[c]) && !(cfg_z[c] && rd == 0);
      if (ce) begin
        for (int p = 0; p < 2; p++) begin
          idx = (p == 0) ? rs0 : rs1;
          v = '0;
          if (idx < cfg_n[c]) begin
            if (cfg_z[c] && idx == 0) v = '0;
            else if (cfg_b[c] && wfire && rd == idx) v = din;
            else v = m_mem[c][idx];
          end
          m_rs[c][p] = v;
        end
      end
      if (wfire) m_mem[c][rd] = din;
      if (clr) begin
        m_clear[c] = 1'b1;
        m_ptr[c]   = 0;
      end
    end
    exp_q.push_back(m_rs[c][0]);
    exp_q.push_back(m_rs[c][1]);
    exp_q.push_back({31'b0, m_clear[c]});
  endtask

  // driver: one posedge per call, outputs sampled 1ns after the edge
  task automatic step(input string tag, input bit rst_low, input bit ce, input bit we, input int rd,
                      input logic [XLEN-1:0] din, input int rs0, input int rs1, input bit clr);
    logic [XLEN-1:0] got [6];
    rst_n = !rst_low;
    t_ce  = ce;
    t_we  = we;
    t_rd  = IDX_W'(rd);
    t_din = din;
    t_rs  = {IDX_W'(rs1), IDX_W'(rs0)};
    t_clr = clr;
    for (int c = 0; c < 2; c++) model_edge(c, rst_low, ce, we, rd, din, rs0, rs1, clr);
    @(posedge clk);
    #1;
    got[0] = bus_a.rs_data[31:0];
    got[1] = bus_a.rs_data[63:32];
    got[2] = {31'b0, bus_a.busy};
    got[3] = bus_b.rs_data[31:0];
    got[4] = bus_b.rs_data[63:32];
    got[5] = {31'b0, bus_b.busy};
    for (int k = 0; k < 6; k++)
      check_val($sformatf("%s %s %s", tag, (k < 3) ? "a" : "b",
                          (k % 3 == 2) ? "busy" : ((k % 3 == 0) ? "rs0" : "rs1")),
                got[k], exp_q.pop_front());
  endtask

  initial begin
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) m_mem[c][i] = '0;

    // reset then full sweep; busy is checked on every edge
    step("rst", 1, 0, 0, 0, 0, 0, 0, 0);
    step("rst", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step("sweep", 0, 1, 0, 0, 0, 5, 31, 0);
    step("rd_5_31", 0, 1, 0, 0, 0, 5, 31, 0);

    // write then read latency, ce=0 hold
    step("wr_x7", 0, 1, 1, 7, 32'hDEADBEEF, 1, 2, 0);
    step("rd_x7", 0, 1, 0, 0, 0, 7, 2, 0);
    step("rd_x7_out", 0, 1, 0, 0, 0, 3, 7, 0);
    step("ce0_hold", 0, 0, 1, 9, 32'h11111111, 3, 9, 0);
    step("ce0_nowr", 0, 1, 0, 0, 0, 9, 7, 0);

    // same-cycle write/read of x3
    step("bypass_x3", 0, 1, 1, 3, 32'h12345678, 7, 3, 0);
    step("after_x3", 0, 1, 0, 0, 0, 3, 3, 0);

    // entry 0 writes
    step("wr_x0", 0, 1, 1, 0, 32'hFFFFFFFF, 7, 3, 0);
    step("rd_x0", 0, 1, 0, 0, 0, 0, 0, 0);

    // fill, clear request with concurrent write, writes during busy
    for (int i = 1; i < 32; i++)
      step("fill", 0, 1, 1, i, $urandom | 32'h1, $urandom_range(0, 31), $urandom_range(0, 31), 0);
    step("clr_req", 0, 1, 1, 4, 32'hAA, 4, 5, 1);
    for (int i = 0; i < 32; i++)
      step("busy_wr", 0, 1, 1, $urandom_range(0, 31), $urandom, $urandom_range(0, 31), 4, 0);
    for (int i = 0; i < 32; i += 2) step("post_clr", 0, 1, 0, 0, 0, i, i + 1, 0);
    step("post_clr", 0, 1, 0, 0, 0, 0, 0, 0);

    // reset mid-sweep at ptr 10, then out-of-range index
    step("fill2", 0, 1, 1, 12, 32'hCAFE0012, 0, 0, 0);
    step("clr2", 0, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step("sweep2", 0, 1, 0, 0, 0, 12, 0, 0);
    step("rst_mid", 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step("sweep3", 0, 1, 0, 0, 0, 12, 30, 0);
    step("wr_x30", 0, 1, 1, 30, 32'h55AA55AA, 30, 12, 0);
    step("rd_x30", 0, 1, 0, 0, 0, 30, 30, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), $urandom_range(0, 1),
           $urandom_range(0, 31), $urandom, $urandom_range(0, 31), $urandom_range(0, 31),
           ($urandom_range(0, 49) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
